// File: rtl/jesd204_link_bringup_ctrl.sv
// jesd204_link_bringup_ctrl
//
// Sequences bring-up of a JESD204 link layer. The controller:
//   1. holds the link in reset,
//   2. releases it and waits for SYNC to deassert,
//   3. waits for every enabled lane's elastic buffer to report IFS ready,
//   4. checks each enabled lane's measured latency against a window.
// It then declares link-up, or retries the whole sequence up to a bounded
// number of times before parking in FAIL.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   ctrl_enable            level request to bring the link up (0 forces IDLE)
//   cfg_lanes_disable      per-lane ignore mask for all checks
//   cfg_latency_min/max    inclusive latency window (unsigned)
//   sync                   link SYNC, active-low
//   status_lane_ifs_ready  per-lane elastic-buffer ready
//   status_lane_latency    packed per-lane latency, lane i at [i*LATENCY_WIDTH +: LATENCY_WIDTH]
//   link_reset             reset to the link layer
//   link_enable            enable to the link layer
//   status_state           current state encoding
//   status_link_up         high in UP
//   status_fail            high in FAIL
//   status_retry_cnt       retries taken in the current attempt
//   status_latency_err     per-lane latency violation captured in CHECK
//   event_retry            one-cycle pulse per retry
module jesd204_link_bringup_ctrl #(
    parameter int NUM_LANES     = 4,
    parameter int LATENCY_WIDTH = 14,
    parameter int HOLD_CYCLES   = 16,
    parameter int SYNC_TIMEOUT  = 4096,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ctrl_enable,
    input  logic [NUM_LANES-1:0]               cfg_lanes_disable,
    input  logic [LATENCY_WIDTH-1:0]           cfg_latency_min,
    input  logic [LATENCY_WIDTH-1:0]           cfg_latency_max,
    input  logic                               sync,
    input  logic [NUM_LANES-1:0]               status_lane_ifs_ready,
    input  logic [NUM_LANES*LATENCY_WIDTH-1:0] status_lane_latency,
    output logic                               link_reset,
    output logic                               link_enable,
    output logic [2:0]                         status_state,
    output logic                               status_link_up,
    output logic                               status_fail,
    output logic [7:0]                         status_retry_cnt,
    output logic [NUM_LANES-1:0]               status_latency_err,
    output logic                               event_retry
);

    localparam int TIMER_SPAN = (HOLD_CYCLES > SYNC_TIMEOUT) ? HOLD_CYCLES : SYNC_TIMEOUT;
    localparam int TIMER_W    = $clog2(TIMER_SPAN) + 1;

    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SYNC_LAST   = TIMER_W'(SYNC_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_SAT   = {TIMER_W{1'b1}};
    localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_SYNC = 3'd2,
        S_WAIT_IFS  = 3'd3,
        S_CHECK     = 3'd4,
        S_UP        = 3'd5,
        S_RETRY     = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [7:0]           retry_cnt_r;
    logic [7:0]           retry_cnt_next_s;
    logic [NUM_LANES-1:0] latency_err_r;
    logic [NUM_LANES-1:0] lat_err_s;
    logic                 lanes_ok_s;

    logic                 link_reset_r;
    logic                 link_enable_r;
    logic                 link_up_r;
    logic                 fail_r;
    logic                 event_retry_r;

    logic                 link_reset_s;
    logic                 link_enable_s;
    logic                 link_up_s;
    logic                 fail_s;
    logic                 event_retry_s;

    // Every lane that is not masked off must report its buffer ready.
    assign lanes_ok_s = &(status_lane_ifs_ready | cfg_lanes_disable);

    // Per-lane latency window check; masked lanes never flag an error.
    always_comb begin
        lat_err_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!cfg_lanes_disable[i] &&
                ((status_lane_latency[i*LATENCY_WIDTH +: LATENCY_WIDTH] < cfg_latency_min) ||
                 (status_lane_latency[i*LATENCY_WIDTH +: LATENCY_WIDTH] > cfg_latency_max))) begin
                lat_err_s[i] = 1'b1;
            end else begin
                lat_err_s[i] = 1'b0;
            end
        end
    end

    // Next-state and retry-count logic; dropping ctrl_enable overrides every state.
    always_comb begin
        state_next_s     = state_r;
        retry_cnt_next_s = retry_cnt_r;
        if (!ctrl_enable) begin
            state_next_s     = S_IDLE;
            retry_cnt_next_s = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_next_s     = S_RESET;
                    retry_cnt_next_s = 8'd0;
                end
                S_RESET: begin
                    if (timer_r == HOLD_LAST) begin
                        state_next_s = S_WAIT_SYNC;
                    end else begin
                        state_next_s = S_RESET;
                    end
                end
                S_WAIT_SYNC: begin
                    // A sync arriving on the timeout cycle still counts as success.
                    if (sync) begin
                        state_next_s = S_WAIT_IFS;
                    end else if (timer_r == SYNC_LAST) begin
                        state_next_s = S_RETRY;
                    end else begin
                        state_next_s = S_WAIT_SYNC;
                    end
                end
                S_WAIT_IFS: begin
                    // Losing sync here aborts ahead of a coincident lanes-ready.
                    if (!sync) begin
                        state_next_s = S_RETRY;
                    end else if (lanes_ok_s) begin
                        state_next_s = S_CHECK;
                    end else if (timer_r == SYNC_LAST) begin
                        state_next_s = S_RETRY;
                    end else begin
                        state_next_s = S_WAIT_IFS;
                    end
                end
                S_CHECK: begin
                    if (|lat_err_s) begin
                        state_next_s = S_RETRY;
                    end else begin
                        state_next_s = S_UP;
                    end
                end
                S_UP: begin
                    if (!sync || !lanes_ok_s) begin
                        state_next_s = S_RETRY;
                    end else begin
                        state_next_s = S_UP;
                    end
                end
                S_RETRY: begin
                    if (retry_cnt_r == RETRY_LIMIT) begin
                        state_next_s = S_FAIL;
                    end else begin
                        state_next_s     = S_RESET;
                        retry_cnt_next_s = retry_cnt_r + 8'd1;
                    end
                end
                S_FAIL: begin
                    state_next_s = S_FAIL;
                end
                default: begin
                    state_next_s     = S_IDLE;
                    retry_cnt_next_s = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track status_state.
    always_comb begin
        link_reset_s  = 1'b1;
        link_enable_s = 1'b0;
        link_up_s     = 1'b0;
        fail_s        = 1'b0;
        event_retry_s = 1'b0;
        case (state_next_s)
            S_IDLE, S_RESET: begin
                link_reset_s  = 1'b1;
                link_enable_s = 1'b0;
            end
            S_WAIT_SYNC, S_WAIT_IFS, S_CHECK: begin
                link_reset_s  = 1'b0;
                link_enable_s = 1'b1;
            end
            S_UP: begin
                link_reset_s  = 1'b0;
                link_enable_s = 1'b1;
                link_up_s     = 1'b1;
            end
            S_RETRY: begin
                link_reset_s  = 1'b1;
                event_retry_s = 1'b1;
            end
            S_FAIL: begin
                link_reset_s  = 1'b1;
                fail_s        = 1'b1;
            end
            default: begin
                link_reset_s  = 1'b1;
                link_enable_s = 1'b0;
            end
        endcase
    end

    // State and retry counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            retry_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            retry_cnt_r <= retry_cnt_next_s;
        end
    end

    // Dwell timer: zeroed on every state change, saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= '0;
        end else if (state_next_s != state_r) begin
            timer_r <= '0;
        end else if (timer_r != TIMER_SAT) begin
            timer_r <= timer_r + TIMER_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Latency error capture: latched in CHECK, cleared on the way into IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            latency_err_r <= '0;
        end else if (state_next_s == S_IDLE) begin
            latency_err_r <= '0;
        end else if (state_r == S_CHECK) begin
            latency_err_r <= lat_err_s;
        end else begin
            latency_err_r <= latency_err_r;
        end
    end

    // Registered link controls and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            link_reset_r  <= 1'b1;
            link_enable_r <= 1'b0;
            link_up_r     <= 1'b0;
            fail_r        <= 1'b0;
            event_retry_r <= 1'b0;
        end else begin
            link_reset_r  <= link_reset_s;
            link_enable_r <= link_enable_s;
            link_up_r     <= link_up_s;
            fail_r        <= fail_s;
            event_retry_r <= event_retry_s;
        end
    end

    assign link_reset         = link_reset_r;
    assign link_enable        = link_enable_r;
    assign status_state       = state_r;
    assign status_link_up     = link_up_r;
    assign status_fail        = fail_r;
    assign status_retry_cnt   = retry_cnt_r;
    assign status_latency_err = latency_err_r;
    assign event_retry        = event_retry_r;

endmodule

// File: tb/tb_jesd204_link_bringup_ctrl.sv
// Testbench for jesd204_link_bringup_ctrl: a latency-window vector table,
// hand-written multi-cycle sequences and a randomized run. Every cycle is
// also compared against a dwell-time based reference model.
module tb_jesd204_link_bringup_ctrl;

    localparam int NL   = 4;
    localparam int LW   = 14;
    localparam int HOLD = 16;
    localparam int TO   = 64;
    localparam int MAXR = 3;

    localparam int ST_IDLE = 0, ST_RESET = 1, ST_WSYNC = 2, ST_WIFS = 3,
                   ST_CHECK = 4, ST_UP = 5, ST_RETRY = 6, ST_FAIL = 7;

    logic              clk;
    logic              reset;
    logic              ctrl_enable;
    logic [NL-1:0]     dis;
    logic [LW-1:0]     lmin;
    logic [LW-1:0]     lmax;
    logic              sync;
    logic [NL-1:0]     ifs;
    logic [NL*LW-1:0]  lat;
    logic              link_reset;
    logic              link_enable;
    logic [2:0]        status_state;
    logic              status_link_up;
    logic              status_fail;
    logic [7:0]        status_retry_cnt;
    logic [NL-1:0]     status_latency_err;
    logic              event_retry;

    int tests    = 0;
    int failures = 0;
    int edge_no  = 0;

    // Reference model: state number, edge at which it was entered, retries, errors.
    int        m_state   = ST_IDLE;
    int        m_entry   = 0;
    int        m_retries = 0;
    logic [3:0] m_err    = 4'b0000;

    jesd204_link_bringup_ctrl #(
        .NUM_LANES(NL), .LATENCY_WIDTH(LW), .HOLD_CYCLES(HOLD),
        .SYNC_TIMEOUT(TO), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .ctrl_enable(ctrl_enable),
        .cfg_lanes_disable(dis), .cfg_latency_min(lmin), .cfg_latency_max(lmax),
        .sync(sync), .status_lane_ifs_ready(ifs), .status_lane_latency(lat),
        .link_reset(link_reset), .link_enable(link_enable), .status_state(status_state),
        .status_link_up(status_link_up), .status_fail(status_fail),
        .status_retry_cnt(status_retry_cnt), .status_latency_err(status_latency_err),
        .event_retry(event_retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        int         nxt;
        int         dwell;
        logic [3:0] bad;
        logic       ok;
        logic [LW-1:0] li;
        edge_no = edge_no + 1;
        ok  = &(ifs | dis);
        bad = 4'b0000;
        for (int i = 0; i < NL; i++) begin
            li = lat[i*LW +: LW];
            if (!dis[i] && (li < lmin || li > lmax)) bad[i] = 1'b1;
        end
        if (reset) begin
            m_state = ST_IDLE; m_entry = edge_no; m_retries = 0; m_err = 4'b0000;
            return;
        end
        dwell = edge_no - m_entry;   // cycles already spent in the current state
        nxt   = m_state;
        if (!ctrl_enable) begin
            nxt = ST_IDLE;
        end else begin
            case (m_state)
                ST_IDLE:  nxt = ST_RESET;
                ST_RESET: if (dwell == HOLD) nxt = ST_WSYNC;
                ST_WSYNC: begin
                    if (sync) nxt = ST_WIFS;
                    else if (dwell == TO) nxt = ST_RETRY;
                end
                ST_WIFS: begin
                    if (!sync) nxt = ST_RETRY;
                    else if (ok) nxt = ST_CHECK;
                    else if (dwell == TO) nxt = ST_RETRY;
                end
                ST_CHECK: begin
                    m_err = bad;
                    nxt = (bad != 4'b0000) ? ST_RETRY : ST_UP;
                end
                ST_UP: if (!sync || !ok) nxt = ST_RETRY;
                ST_RETRY: begin
                    if (m_retries == MAXR) nxt = ST_FAIL;
                    else begin m_retries = m_retries + 1; nxt = ST_RESET; end
                end
                default: nxt = m_state;
            endcase
        end
        if (nxt == ST_IDLE) begin m_retries = 0; m_err = 4'b0000; end
        if (nxt != m_state) m_entry = edge_no;
        m_state = nxt;
    endtask

    function automatic logic [19:0] expected_vec();
        logic lr, le;
        lr = (m_state == ST_IDLE || m_state == ST_RESET || m_state == ST_RETRY || m_state == ST_FAIL);
        le = (m_state >= ST_WSYNC && m_state <= ST_UP);
        return {3'(m_state), lr, le, (m_state == ST_UP), (m_state == ST_FAIL),
                8'(m_retries), m_err, (m_state == ST_RETRY)};
    endfunction

    task automatic step();
        logic [19:0] act;
        logic [19:0] exp;
        model_edge();
        @(posedge clk);
        #1;
        act = {status_state, link_reset, link_enable, status_link_up, status_fail,
               status_retry_cnt, status_latency_err, event_retry};
        exp = expected_vec();
        tests = tests + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL model_edge%0d: got %h expected %h", edge_no, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (status_state != target && n < budget) begin
            step();
            n = n + 1;
        end
        chk("wait_state_reached", 32'(status_state), 32'(target));
    endtask

    task automatic go_idle();
        ctrl_enable = 1'b0;
        step();
        chk("go_idle_state", 32'(status_state), 32'd0);
    endtask

    task automatic reach_wait_ifs();
        ctrl_enable = 1'b1; sync = 1'b0; ifs = 4'b0000;
        wait_state(3'd2, 40);
        sync = 1'b1;
        step();
        chk("enter_wait_ifs", 32'(status_state), 32'd3);
    endtask

    task automatic reach_check();
        reach_wait_ifs();
        ifs = 4'b1111;
        step();
        chk("enter_check", 32'(status_state), 32'd4);
    endtask

    task automatic set_nominal();
        dis  = 4'b0000;
        lmin = 14'd8;
        lmax = 14'd16;
        lat  = {14'd13, 14'd12, 14'd11, 14'd10};
    endtask

    typedef struct {
        logic [3:0]     dis;
        logic [NL*LW-1:0] lat;
        logic [LW-1:0]  lmin;
        logic [LW-1:0]  lmax;
        logic [3:0]     exp_err;
        logic [2:0]     exp_state;
    } lat_vec_t;

    lat_vec_t vecs [9];

    initial begin
        int n;
        int hi;

        vecs[0] = '{4'b0000, {14'd13, 14'd12, 14'd11, 14'd10}, 14'd8,  14'd16, 4'b0000, 3'd5};
        vecs[1] = '{4'b0000, {14'd13, 14'd20, 14'd11, 14'd10}, 14'd8,  14'd16, 4'b0100, 3'd6};
        vecs[2] = '{4'b0100, {14'd13, 14'd20, 14'd11, 14'd10}, 14'd8,  14'd16, 4'b0000, 3'd5};
        vecs[3] = '{4'b0000, {14'd17, 14'd7,  14'd16, 14'd8},  14'd8,  14'd16, 4'b1100, 3'd6};
        vecs[4] = '{4'b0000, {14'd13, 14'd12, 14'd11, 14'd10}, 14'd16, 14'd8,  4'b1111, 3'd6};
        vecs[5] = '{4'b1111, {14'd13, 14'd12, 14'd11, 14'd10}, 14'd16, 14'd8,  4'b0000, 3'd5};
        vecs[6] = '{4'b0000, {14'd0,  14'd0,  14'd0,  14'd0},  14'd0,  14'd0,  4'b0000, 3'd5};
        vecs[7] = '{4'b0000, {14'd16383, 14'd16383, 14'd0, 14'd0}, 14'd0, 14'd16383, 4'b0000, 3'd5};
        vecs[8] = '{4'b0101, {14'd13, 14'd12, 14'd11, 14'd10}, 14'd16, 14'd8,  4'b1010, 3'd6};

        reset = 1'b1; ctrl_enable = 1'b0; sync = 1'b0; ifs = 4'b0000;
        set_nominal();

        // Reset state.
        step();
        step();
        chk("reset_state", 32'(status_state), 32'd0);
        chk("reset_link_reset", 32'(link_reset), 32'd1);
        chk("reset_link_enable", 32'(link_enable), 32'd0);
        reset = 1'b0;

        // Nominal bring-up.
        ctrl_enable = 1'b1;
        step();
        chk("nominal_reset_entry", 32'(status_state), 32'd1);
        hi = 0; n = 0;
        while (status_state == 3'd1 && n < 40) begin
            if (link_reset) hi = hi + 1;
            step();
            n = n + 1;
        end
        chk("nominal_hold_cycles", 32'(hi), 32'd16);
        chk("nominal_wait_sync", 32'(status_state), 32'd2);
        chk("nominal_link_released", 32'(link_reset), 32'd0);
        for (int i = 0; i < 39; i++) step();
        sync = 1'b1;
        step();
        chk("nominal_wait_ifs", 32'(status_state), 32'd3);
        for (int i = 0; i < 20; i++) step();
        chk("nominal_still_wait_ifs", 32'(status_state), 32'd3);
        ifs = 4'b1111;
        step();
        chk("nominal_check", 32'(status_state), 32'd4);
        step();
        chk("nominal_up", 32'(status_state), 32'd5);
        chk("nominal_link_up", 32'(status_link_up), 32'd1);
        chk("nominal_retry_cnt", 32'(status_retry_cnt), 32'd0);
        chk("nominal_lat_err", 32'(status_latency_err), 32'd0);

        // Latency-window vector table.
        for (int v = 0; v < 9; v++) begin
            go_idle();
            chk("table_err_cleared", 32'(status_latency_err), 32'd0);
            dis = vecs[v].dis; lat = vecs[v].lat; lmin = vecs[v].lmin; lmax = vecs[v].lmax;
            reach_check();
            step();
            chk("table_lat_err", 32'(status_latency_err), 32'(vecs[v].exp_err));
            chk("table_next_state", 32'(status_state), 32'(vecs[v].exp_state));
            if (vecs[v].exp_state == 3'd6) begin
                step();
                chk("table_retry_to_reset", 32'(status_state), 32'd1);
                chk("table_retry_cnt", 32'(status_retry_cnt), 32'd1);
                chk("table_err_held", 32'(status_latency_err), 32'(vecs[v].exp_err));
            end
        end

        // Sync timeout all the way to FAIL.
        go_idle();
        set_nominal();
        ctrl_enable = 1'b1; sync = 1'b0; ifs = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            wait_state(3'd2, 40);
            n = 0;
            while (!event_retry && n < 100) begin
                step();
                n = n + 1;
            end
            chk("timeout_spacing", 32'(n), 32'd64);
            chk("timeout_cnt_at_retry", 32'(status_retry_cnt), 32'(r));
        end
        step();
        chk("fail_state", 32'(status_state), 32'd7);
        chk("fail_flag", 32'(status_fail), 32'd1);
        chk("fail_retry_cnt", 32'(status_retry_cnt), 32'd3);
        for (int i = 0; i < 10; i++) step();
        chk("fail_held", 32'(status_state), 32'd7);
        ctrl_enable = 1'b0;
        step();
        chk("fail_exit_idle", 32'(status_state), 32'd0);
        chk("fail_exit_cnt", 32'(status_retry_cnt), 32'd0);
        chk("fail_exit_flag", 32'(status_fail), 32'd0);

        // Link loss in UP: a one-cycle sync drop, then a lane-0 ready drop.
        set_nominal();
        reach_check();
        step();
        chk("loss_up", 32'(status_state), 32'd5);
        sync = 1'b0;
        step();
        chk("loss_sync_retry", 32'(event_retry), 32'd1);
        sync = 1'b1;
        step();
        chk("loss_sync_reset", 32'(status_state), 32'd1);
        chk("loss_sync_cnt", 32'(status_retry_cnt), 32'd1);
        wait_state(3'd5, 60);
        ifs = 4'b1110;
        step();
        chk("loss_ifs_retry", 32'(event_retry), 32'd1);
        ifs = 4'b1111;
        step();
        chk("loss_ifs_reset", 32'(status_state), 32'd1);
        chk("loss_ifs_cnt", 32'(status_retry_cnt), 32'd2);

        // Reset asserted while UP.
        wait_state(3'd5, 60);
        reset = 1'b1;
        step();
        chk("rst_up_state", 32'(status_state), 32'd0);
        chk("rst_up_link_reset", 32'(link_reset), 32'd1);
        chk("rst_up_link_enable", 32'(link_enable), 32'd0);
        chk("rst_up_link_up", 32'(status_link_up), 32'd0);
        chk("rst_up_cnt", 32'(status_retry_cnt), 32'd0);
        reset = 1'b0;

        // ctrl_enable dropped during WAIT_IFS.
        go_idle();
        reach_wait_ifs();
        ctrl_enable = 1'b0;
        step();
        chk("abort_ifs_idle", 32'(status_state), 32'd0);
        chk("abort_ifs_link_reset", 32'(link_reset), 32'd1);

        // Sync rising on the WAIT_SYNC timeout cycle.
        ctrl_enable = 1'b1; sync = 1'b0; ifs = 4'b0000;
        wait_state(3'd2, 40);
        for (int i = 0; i < 63; i++) step();
        chk("coincide_still_wait", 32'(status_state), 32'd2);
        sync = 1'b1;
        step();
        chk("coincide_wait_ifs", 32'(status_state), 32'd3);
        chk("coincide_no_retry", 32'(event_retry), 32'd0);

        // Randomized run against the model.
        go_idle();
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 799) == 0);
            ctrl_enable = ($urandom_range(0, 299) != 0);
            if (sync) begin
                if ($urandom_range(0, 49) == 0) sync = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) sync = 1'b1;
            end
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(0, 59) == 0) ifs[i] = ~ifs[i];
                else if (!ifs[i] && $urandom_range(0, 9) == 0) ifs[i] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0)
                dis = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < NL; i++) lat[i*LW +: LW] = 14'($urandom_range(4, 20));
            end
            if ($urandom_range(0, 199) == 0) begin
                lmin = 14'($urandom_range(6, 12));
                lmax = 14'($urandom_range(10, 20));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
